// File: rtl/rot_arb_pkg.sv
// rtl/rot_arb_pkg.sv - shared constants, buffer entry type and amount negation for rot_arb
// Optional right-rotate support (macro ROT_ARB_DIR_EN) uses rot_neg_amt.
package rot_arb_pkg;

    localparam int ROT_DEPTH = 2;
    localparam int ROT_N_DEFAULT = 8;

    // Buffer entry at the default width; rot_arb declares its own N-wide copy.
    typedef struct packed {
        logic                     tag;
        logic [ROT_N_DEFAULT-1:0] data;
    } rot_entry_t;

    // Right rotate by amt equals left rotate by (n - amt) mod n.
    function automatic int unsigned rot_neg_amt(input int unsigned amt, input int unsigned n);
        return (n - (amt % n)) % n;
    endfunction

endpackage

// File: rtl/rot_core.sv
// rtl/rot_core.sv - combinational W-stage left rotator
module rot_core #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] iA,
    input  logic [W-1:0] iAmt,
    output logic [N-1:0] oY
);

    logic [N-1:0] st [0:W];

    assign st[0] = iA;

    // Stage g rotates by 2**g when amount bit g is set.
    for (genvar g = 0; g < W; g++) begin : g_stage
        localparam int SH = 1 << g;
        assign st[g+1] = iAmt[g] ? ((st[g] << SH) | (st[g] >> (N - SH))) : st[g];
    end

    assign oY = st[W];

endmodule

// File: rtl/rot_arb.sv
// rtl/rot_arb.sv - two-requester round-robin rotate arbiter with 2-entry output buffer
// Macro ROT_ARB_DIR_EN adds per-requester direction inputs (0=left, 1=right).
module rot_arb
    import rot_arb_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic         iReq0Valid,
    input  logic [N-1:0] iReq0Data,
    input  logic [W-1:0] iReq0Amt,
`ifdef ROT_ARB_DIR_EN
    input  logic         iReq0Dir,
`endif
    output logic         oReq0Ready,
    input  logic         iReq1Valid,
    input  logic [N-1:0] iReq1Data,
    input  logic [W-1:0] iReq1Amt,
`ifdef ROT_ARB_DIR_EN
    input  logic         iReq1Dir,
`endif
    output logic         oReq1Ready,
    output logic         oValid,
    output logic [N-1:0] oData,
    output logic         oTag,
    input  logic         iReady
);

    typedef struct packed {
        logic         tag;
        logic [N-1:0] data;
    } entry_t;

    entry_t     head_q, tail_q;
    logic [1:0] count_q;
    logic       last_q;

    logic       pop, space, gnt0, gnt1, push;
    logic [N-1:0] sel_data, rot_data;
    logic [W-1:0] sel_amt, rot_amt;
    entry_t     new_entry;

    assign oValid = (count_q != 2'd0);
    assign oData  = head_q.data;
    assign oTag   = head_q.tag;

    // Ready may depend on iReady: a full buffer still accepts when it pops.
    always_comb begin
        pop   = oValid & iReady;
        space = (count_q < 2'(ROT_DEPTH)) | pop;
        gnt0  = space & iReq0Valid & (~iReq1Valid | last_q);
        gnt1  = space & iReq1Valid & (~iReq0Valid | ~last_q);
        push  = gnt0 | gnt1;
    end

    assign oReq0Ready = gnt0;
    assign oReq1Ready = gnt1;

    always_comb begin
        sel_data = gnt1 ? iReq1Data : iReq0Data;
        sel_amt  = gnt1 ? iReq1Amt  : iReq0Amt;
`ifdef ROT_ARB_DIR_EN
        if (gnt1 ? iReq1Dir : iReq0Dir)
            rot_amt = W'(rot_neg_amt(32'(sel_amt), N));
        else
            rot_amt = sel_amt;
`else
        rot_amt = sel_amt;
`endif
    end

    rot_core #(.N(N), .W(W)) u_rot_core (
        .iA   (sel_data),
        .iAmt (rot_amt),
        .oY   (rot_data)
    );

    assign new_entry = '{tag: gnt1, data: rot_data};

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            last_q  <= 1'b1;
        end else begin
            if (push)
                last_q <= gnt1;
            case (count_q)
                2'd0: begin
                    if (push) begin
                        head_q  <= new_entry;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_q <= new_entry;
                    end else if (push) begin
                        tail_q  <= new_entry;
                        count_q <= 2'd2;
                    end else if (pop) begin
                        count_q <= 2'd0;
                    end
                end
                default: begin
                    // A push here always comes with a pop, so count stays at 2.
                    if (pop) begin
                        head_q <= tail_q;
                        if (push)
                            tail_q <= new_entry;
                        else
                            count_q <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule
